// File: rtl/mux_rr_sel_arbiter.sv
// mux_rr_sel_arbiter
//   Four-way round-robin arbiter that drives the 2-bit select of the
//   downstream 4:1 mux. The winner is registered onto o_sel/o_gnt. Each grant
//   lasts at most HOLD_CYC cycles. After every grant there is at least one
//   idle cycle, so the mux select never changes while a grant is active.
//
// Ports
//   i_clk   rising-edge clock
//   i_rst   synchronous reset, active high
//   i_req   per-channel request; i_req[i] selects mux input i
//   i_done  early release by the current owner; only looked at in GRANT
//   o_sel   registered mux select (current owner, or last owner when idle)
//   o_gnt   registered one-hot grant; zero when there is no owner
//   o_busy  high while a grant is active
module mux_rr_sel_arbiter #(
  parameter int HOLD_CYC = 4  // 1..255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic [1:0] o_sel,
  output logic [3:0] o_gnt,
  output logic       o_busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);

  state_t     r_state;
  logic [1:0] r_last;  // round-robin pointer: index of the most recent winner
  logic [7:0] r_cnt;   // grant cycles remaining after the current one
  logic [1:0] r_sel;
  logic [3:0] r_gnt;
  logic       r_busy;

  logic [1:0] w_win;
  logic       w_found;
  logic       w_rel;

  // Scan last+1, last+2, last+3, last (mod 4). The first set request wins.
  always_comb begin
    logic [1:0] idx;
    w_win   = 2'd0;
    w_found = 1'b0;
    idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = r_last + 2'(k);
      if (!w_found && i_req[idx]) begin
        w_win   = idx;
        w_found = 1'b1;
      end
    end
  end

  // Any single release source is enough. When several fire together, the
  // result is the same single release.
  assign w_rel = (r_cnt == 8'd0) | i_done | ~i_req[r_sel];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_cnt   <= 8'd0;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_sel   <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_busy  <= 1'b1;
            r_last  <= w_win;
            r_cnt   <= HOLD_LOAD;
          end
        end
        GRANT: begin
          if (w_rel) begin
            // r_sel is kept so the mux stays on the last owner while idle.
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sel  = r_sel;
  assign o_gnt  = r_gnt;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
module tb_mux_rr_sel_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  mux_rr_sel_arbiter #(.HOLD_CYC(HOLD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_req (req),
    .i_done(done),
    .o_sel (sel),
    .o_gnt (gnt),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model. It tracks who owns the mux and how many grant cycles
  // that owner has used so far.
  int m_owner = -1;  // -1: no owner
  int m_held  = 0;   // grant cycles used by the current owner
  int m_last  = 3;
  int m_sel   = 0;

  function automatic logic [3:0] exp_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  function automatic logic exp_busy();
    return m_owner >= 0;
  endfunction

  // Advance the model using the current inputs, then let the DUT take the
  // same edge. Outputs are sampled on the falling edge.
  task automatic tick();
    if (rst) begin
      m_owner = -1; m_held = 0; m_last = 3; m_sel = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_sel = c; m_last = c; m_held = 1;
        end
      end
    end else begin
      if (m_held >= HOLD || done || !req[m_owner]) m_owner = -1;
      else m_held++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({sel, gnt, busy} !== 7'b00_0000_0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: got sel=%0d gnt=%b busy=%b, want sel=0 gnt=0000 busy=0",
                 i, sel, gnt, busy);
      end
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    for (int i = 1; i <= 6; i++) begin
      logic [3:0] want;
      tick();
      want = (i == 5) ? 4'b0000 : 4'b0100;
      vectors++;
      if (gnt !== want || sel !== 2'd2 || busy !== (want != 0)) begin
        miscompares++;
        $display("FAIL single_hold cyc%0d: got sel=%0d gnt=%b busy=%b, want sel=2 gnt=%b",
                 i, sel, gnt, busy, want);
      end
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int t = 1; t <= 25; t++) begin
      logic [3:0] want;
      int slot, ph;
      tick();
      slot = (t - 1) / 5; ph = (t - 1) % 5;
      want = (ph < 4) ? 4'(1 << (slot % 4)) : 4'b0000;
      vectors++;
      if (gnt !== want || gnt !== exp_gnt() || busy !== exp_busy()) begin
        miscompares++;
        $display("FAIL round_robin t%0d: got gnt=%b busy=%b, want gnt=%b", t, gnt, busy, want);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_early_release();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0010;
    tick();
    vectors++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      miscompares++;
      $display("FAIL early_grant: got sel=%0d gnt=%b, want sel=1 gnt=0010", sel, gnt);
    end
    tick();
    done = 1'b1; req = 4'b1010;
    tick();
    done = 1'b0;
    vectors++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd1) begin
      miscompares++;
      $display("FAIL early_release: got sel=%0d gnt=%b busy=%b, want sel=1 gnt=0000 busy=0",
               sel, gnt, busy);
    end
    tick();
    vectors++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      miscompares++;
      $display("FAIL early_next: got sel=%0d gnt=%b, want sel=3 gnt=1000", sel, gnt);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_req_drop();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1000;
    tick();
    vectors++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      miscompares++;
      $display("FAIL drop_grant: got sel=%0d gnt=%b, want sel=3 gnt=1000", sel, gnt);
    end
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd3) begin
        miscompares++;
        $display("FAIL drop_idle cyc%0d: got sel=%0d gnt=%b busy=%b, want sel=3 gnt=0000 busy=0",
                 i, sel, gnt, busy);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0100;
    tick(); tick();
    vectors++;
    if (gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL midrst_grant: got gnt=%b, want 0100", gnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({sel, gnt, busy} !== 7'b00_0000_0) begin
      miscompares++;
      $display("FAIL midrst_reset: got sel=%0d gnt=%b busy=%b, want 0/0000/0", sel, gnt, busy);
    end
    req = 4'b1111;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      miscompares++;
      $display("FAIL midrst_first: got sel=%0d gnt=%b, want sel=0 gnt=0001", sel, gnt);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      // Keep requests fairly dense so grants run to different lengths.
      req  = 4'($urandom) | 4'($urandom);
      done = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      tick();
      vectors++;
      if (gnt !== exp_gnt() || busy !== exp_busy() || sel !== 2'(m_sel)) begin
        miscompares++;
        $display("FAIL random cyc%0d: got sel=%0d gnt=%b busy=%b, want sel=%0d gnt=%b busy=%b",
                 i, sel, gnt, busy, m_sel, exp_gnt(), exp_busy());
      end
      vectors++;
      if (busy !== (|gnt) || (gnt != 0 && gnt !== 4'(1 << sel)) || $countones(gnt) > 1) begin
        miscompares++;
        $display("FAIL invariant cyc%0d: got sel=%0d gnt=%b busy=%b, want onehot gnt matching sel, busy=|gnt",
                 i, sel, gnt, busy);
      end
    end
    rst = 1'b0; done = 1'b0; req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_req_drop();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
